// File: rtl/mac_pkg.sv
// Shared defaults and state encoding for the MAC accumulator slice.
package mac_pkg;

    localparam int DATA_W  = 4;
    localparam int ACC_W   = 10;
    localparam int VEC_LEN = 4;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } mac_state_t;

endpackage

// File: rtl/mul_unsigned.sv
// Combinational unsigned shift-and-add multiplier, DATA_W x DATA_W -> 2*DATA_W.
module mul_unsigned #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] prod
);

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] acc;

    assign a_ext = {{DATA_W{1'b0}}, a};

    always_comb begin
        acc = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (b[i]) begin
                acc = acc + (a_ext << i);
            end
        end
    end

    assign prod = acc;

endmodule

// File: rtl/mac_accumulator.sv
// Sequential multiply-accumulate producing one dot-product term per VEC_LEN beats.
// Build option: MAC_SAT_EN selects saturating accumulation instead of wrapping.
module mac_accumulator #(
    parameter int DATA_W  = mac_pkg::DATA_W,
    parameter int ACC_W   = mac_pkg::ACC_W,
    parameter int VEC_LEN = mac_pkg::VEC_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);
    // state | meaning
    // ACC   | accepting a/b pairs into the accumulator
    // HOLD  | presenting out_sum/out_ovf until out_ready

    import mac_pkg::*;

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    mac_state_t state_q, state_d;

    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                sticky_q;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W:0]      prod_ext;
    logic [ACC_W:0]      sum;
    logic                ovf;
    logic [ACC_W-1:0]    acc_next;
    logic                accept;
    logic                last_beat;

    mul_unsigned #(.DATA_W(DATA_W)) u_mul (
        .a    (a),
        .b    (b),
        .prod (prod)
    );

    assign prod_ext  = {{(ACC_W + 1 - 2*DATA_W){1'b0}}, prod};
    assign sum       = {1'b0, acc_q} + prod_ext;
    assign ovf       = sum[ACC_W];
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_q == CNT_W'(VEC_LEN - 1));

`ifdef MAC_SAT_EN
    // Once clamped, any further nonzero product overflows again, so it stays clamped.
    assign acc_next = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (accept && last_beat) state_d = HOLD;
            HOLD:    if (out_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            out_sum  <= '0;
            out_ovf  <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                out_sum  <= acc_next;
                out_ovf  <= sticky_q | ovf;
                acc_q    <= '0;
                cnt_q    <= '0;
                sticky_q <= 1'b0;
            end else begin
                acc_q    <= acc_next;
                cnt_q    <= cnt_q + 1'b1;
                sticky_q <= sticky_q | ovf;
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed-vector bench for mac_accumulator (default widths plus an ACC_W=8 overflow instance).
module tb_mac_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a, b;
    logic       out_ready;

    logic       in_ready, out_valid, out_ovf;
    logic [9:0] out_sum;
    logic       in_ready8, out_valid8, out_ovf8;
    logic [7:0] out_sum8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    mac_accumulator #(.DATA_W(4), .ACC_W(8), .VEC_LEN(4)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .a         (a),
        .b         (b),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_sum   (out_sum8),
        .out_ovf   (out_ovf8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat i uses av[4*i +: 4] / bv[4*i +: 4]; gap idle cycles after each non-final beat.
    // Returns just after the edge accepting the last beat.
    task automatic send_vec(input logic [15:0] av, input logic [15:0] bv, input int gap);
        int budget;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = av[4*i +: 4];
            b = bv[4*i +: 4];
            budget = 20;
            while (!in_ready && budget > 0) begin
                tick();
                budget--;
            end
            if (budget == 0) chk("accept_timeout", 0, 1);
            if (i == 3) chk("no_early_valid", out_valid, 0);
            tick();
            if (i < 3 && gap > 0) begin
                in_valid = 1'b0;
                a = 4'hf;
                b = 4'hf;
                repeat (gap) tick();
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_ovf", out_ovf, 0);

        // basic: 1*5+2*6+3*7+4*8 = 70, valid for one cycle right after last beat
        send_vec(16'h4321, 16'h8765, 0);
        chk("basic_valid", out_valid, 1);
        chk("basic_sum", out_sum, 70);
        chk("basic_ovf", out_ovf, 0);
        chk("basic_in_ready_hold", in_ready, 0);
        tick();
        chk("basic_valid_drop", out_valid, 0);
        chk("basic_in_ready_back", in_ready, 1);

        // max values: 4*225 = 900
        send_vec(16'hffff, 16'hffff, 0);
        chk("max_sum", out_sum, 900);
        chk("max_ovf", out_ovf, 0);
        tick();

        // backpressure with next pair pending during HOLD
        out_ready = 1'b0;
        send_vec(16'h4321, 16'h8765, 0);
        in_valid = 1'b1; a = 4'd3; b = 4'd3;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", out_sum, 70);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_sum_at_release", out_sum, 70);
        tick();
        chk("bp_in_ready_after_hs", in_ready, 1);
        // pending 3*3 beat is accepted on this first ACC cycle; 4*9 = 36
        send_vec(16'h3333, 16'h3333, 0);
        chk("bp_next_sum", out_sum, 36);
        tick();

        // bubbles between beats
        send_vec(16'h4321, 16'h8765, 2);
        chk("bubble_sum", out_sum, 70);
        chk("bubble_ovf", out_ovf, 0);
        tick();

        // reset after two accepted beats
        in_valid = 1'b1; a = 4'd15; b = 4'd15;
        tick(); tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_sum", out_sum, 0);
        send_vec(16'h2222, 16'h3333, 0);
        chk("midrst_sum", out_sum, 24);
        tick();

        // reset during HOLD discards the pending result
        out_ready = 1'b0;
        send_vec(16'h4321, 16'h8765, 0);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk("holdrst_out_valid", out_valid, 0);
        chk("holdrst_out_sum", out_sum, 0);

        // overflow on the 8-bit accumulator instance
        send_vec(16'hffff, 16'hffff, 0);
        chk("ovf10_sum", out_sum, 900);
        chk("ovf10_ovf", out_ovf, 0);
        chk("ovf8_valid", out_valid8, 1);
`ifdef MAC_SAT_EN
        chk("ovf8_sum_sat", out_sum8, 255);
`else
        chk("ovf8_sum_wrap", out_sum8, 132);
`endif
        chk("ovf8_ovf", out_ovf8, 1);
        tick();

        // sticky flag cleared for the next vector on the 8-bit instance: 70 fits
        send_vec(16'h4321, 16'h8765, 0);
        chk("ovf8_next_sum", out_sum8, 70);
        chk("ovf8_next_ovf", out_ovf8, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential multiply-accumulate stage of the matrix multiplication accelerator. It accepts one element pair (row element `a`, column element `b`) per handshake, multiplies them, and accumulates `VEC_LEN` products into a single `ACC_W`-bit dot-product term. The completed term is then presented to the output-matrix writer. Its accumulator add is the 10-bit ripple adder datapath; with default widths the dot product of four 4-bit vectors (max 900) fits in 10 bits.

## Interface

Parameters:
- `DATA_W`, default 4: element width of `a` and `b` (unsigned).
- `ACC_W`, default 10: accumulator and result width; must be ≥ 2·`DATA_W`.
- `VEC_LEN`, default 4: products per dot product; must be ≥ 1.

Ports:
- `clk`, input, 1: sole clock. One clock; reset is synchronous and active-high.
- `rst`, input, 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_valid`, input, 1: the `a`/`b` pair is valid.
- `in_ready`, output, 1: the block can accept a pair.
- `a`, input, `DATA_W`: row element.
- `b`, input, `DATA_W`: column element.
- `out_valid`, output, 1: `out_sum` holds a completed dot product.
- `out_ready`, input, 1: the consumer takes the result.
- `out_sum`, output, `ACC_W`: dot-product result.
- `out_ovf`, output, 1: an overflow occurred during this dot product.

## Operation

- State machine has two states:
  - `ACC`: accepting pairs.
  - `HOLD`: presenting a result.
- `in_ready` = (state == `ACC`).
- `out_valid` = (state == `HOLD`).
- An input beat is accepted when `in_valid && in_ready`. On acceptance:
  - product = `a`·`b`, a full 2·`DATA_W`-bit unsigned value, zero-extended to `ACC_W+1` bits.
  - sum = acc + product.
  - Overflow is flagged when bit `ACC_W` of sum is set.
  - The sticky overflow bit ORs in that flag.
  - `cnt` increments.
- When a beat is accepted with `cnt == VEC_LEN-1`:
  - the final sum and final sticky overflow load into `out_sum`/`out_ovf`;
  - acc and `cnt` clear;
  - the sticky overflow bit clears;
  - state moves to `HOLD`.
- In `HOLD`, `out_sum` and `out_ovf` are stable. No input is accepted.
- When `out_valid && out_ready`, state returns to `ACC`.
- `in_valid` low in `ACC` leaves acc and `cnt` unchanged. Bubbles between beats are legal.
- Overflow handling is set by the Configuration section.
- `a` and `b` are ignored when the beat is not accepted.

## Timing

- Reset values: state `ACC`, acc = 0, `cnt` = 0, sticky overflow = 0, `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_ovf` = 0.
- A beat accepted at edge k updates acc at edge k. There is no multiplier pipeline register.
- Latency: `out_valid` rises in the cycle after the edge that accepts the last beat.
- Minimum period per dot product is `VEC_LEN`+1 cycles: `VEC_LEN` input beats plus 1 output cycle, with `out_ready` held high.
- `out_ready` is ignored while `out_valid` = 0.
- `in_valid` may be held high through `HOLD`. The pending pair is accepted on the first cycle back in `ACC`, which is the cycle after the output handshake.
- Reset mid-vector or in `HOLD` discards partial sums and any pending result. The next accepted beat is element 0.
- Reset has priority over any simultaneous handshake.

## Configuration

- `MAC_SAT_EN` defined: on overflow the accumulator clamps to 2^`ACC_W`−1 and stays clamped for the rest of the vector. `out_ovf` = 1.
- `MAC_SAT_EN` undefined: the accumulator wraps modulo 2^`ACC_W`. `out_ovf` still reports that a wrap occurred.

## Structure

- Package `mac_pkg` holds:
  - default width constants `DATA_W`, `ACC_W`, `VEC_LEN`;
  - the `ACC`/`HOLD` state enum.
- Sub-module `mul_unsigned`: combinational `DATA_W`×`DATA_W` shift-and-add multiplier, 2·`DATA_W`-bit output, instantiated once.
- The accumulator adder is inline in `mac_accumulator`.

## Test plan

- Basic sum: feed `a` = 1,2,3,4 and `b` = 5,6,7,8 back-to-back with `out_ready` = 1. Expect `out_sum` = 70, `out_ovf` = 0, and `out_valid` for exactly one cycle, in cycle 5 after the first beat.
- Max values: feed `a` = `b` = 15 for four beats. Expect `out_sum` = 900 and `out_ovf` = 0.
- Backpressure: hold `out_ready` = 0 for 3 cycles after a result of 70. Expect `out_sum` held at 70 and `in_ready` = 0 throughout. The next vector is accepted only after the handshake.
- Bubbles: insert `in_valid` = 0 cycles between beats of the 1..4 / 5..8 vector. Expect `out_sum` = 70.
- Reset mid-vector: reset after 2 accepted beats, then feed `a` = 2,2,2,2 and `b` = 3,3,3,3. Expect `out_sum` = 24.
- Overflow, with `ACC_W` = 8 and `a` = `b` = 15 for four beats:
  - with `MAC_SAT_EN`: expect `out_sum` = 255 and `out_ovf` = 1;
  - without it: expect `out_sum` = 900 mod 256 = 132 and `out_ovf` = 1.
